// File: rtl/ryu_pkg.sv
// Shared types and sprite codes for the Ryu action controller.
package ryu_pkg;

  typedef enum logic [1:0] {
    STAND = 2'd0,
    PUNCH = 2'd1,
    JUMP  = 2'd2
  } ryu_state_t;

  localparam logic [2:0] SPR_STAND = 3'd0;
  localparam logic [2:0] SPR_PUNCH = 3'd1;
  localparam logic [2:0] SPR_JUMP  = 3'd2;

  localparam int CNT_W = 8;
  localparam int VY_W  = 8;

  function automatic logic [2:0] sprite_of(input ryu_state_t st);
    case (st)
      STAND:   return SPR_STAND;
      PUNCH:   return SPR_PUNCH;
      JUMP:    return SPR_JUMP;
      default: return SPR_STAND;
    endcase
  endfunction

endpackage

// File: rtl/ryu_key_edge.sv
// Per-frame key history and rising-edge detection for the punch and jump keys.
module ryu_key_edge
  import ryu_pkg::*;
(
  input  logic vga_clk,
  input  logic reset_n,
  input  logic frame_tick,
  input  logic key_punch,
  input  logic key_jump,
  output logic punch_edge,
  output logic jump_edge
);

  logic punch_prev_r;
  logic jump_prev_r;

  // History only advances on ticks, so a key held across frames never re-triggers.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      punch_prev_r <= 1'b0;
      jump_prev_r  <= 1'b0;
    end else if (frame_tick) begin
      punch_prev_r <= key_punch;
      jump_prev_r  <= key_jump;
    end else begin
      punch_prev_r <= punch_prev_r;
      jump_prev_r  <= jump_prev_r;
    end
  end

  assign punch_edge = key_punch & ~punch_prev_r;
  assign jump_edge  = key_jump & ~jump_prev_r;

endmodule

// File: rtl/ryu_action_ctrl.sv
// Stand/punch/jump controller driving Ryu's sprite code and position once per frame.
// Optional macro RYU_AIR_CONTROL_EN enables left/right steering while airborne.
module ryu_action_ctrl
  import ryu_pkg::*;
#(
  parameter int X_START      = 100,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 560,
  parameter int GROUND_Y     = 300,
  parameter int WALK_SPEED   = 2,
  parameter int PUNCH_FRAMES = 8,
  parameter int JUMP_V0      = 12,
  parameter int GRAVITY      = 1
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_punch,
  input  logic       key_jump,
  output logic [9:0] RyuX,
  output logic [9:0] RyuY,
  output logic [2:0] sprite,
  output logic       busy
);

  localparam logic signed [10:0] X_MIN_S    = 11'(X_MIN);
  localparam logic signed [10:0] X_MAX_S    = 11'(X_MAX);
  localparam logic signed [10:0] GROUND_Y_S = 11'(GROUND_Y);
  localparam logic signed [10:0] WALK_S     = 11'(WALK_SPEED);
  localparam logic [CNT_W-1:0]   PUNCH_LAST = CNT_W'(PUNCH_FRAMES - 1);
  localparam logic [VY_W-1:0]    VY_INIT    = VY_W'(JUMP_V0);
  localparam logic [VY_W-1:0]    GRAV_V     = VY_W'(GRAVITY);

  ryu_state_t        state_r;
  logic [VY_W-1:0]   vy_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              punch_edge_s;
  logic              jump_edge_s;
  logic signed [10:0] x_step_s;
  logic signed [10:0] x_sum_s;
  logic [9:0]         walk_x_s;
  logic signed [10:0] y_next_s;
  logic               land_s;

  ryu_key_edge u_key_edge (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .key_punch  (key_punch),
    .key_jump   (key_jump),
    .punch_edge (punch_edge_s),
    .jump_edge  (jump_edge_s)
  );

  // Candidate walking X, computed signed and wide enough that clamping never sees a wrap.
  always_comb begin
    x_step_s = 11'sd0;
    if (key_left ^ key_right) begin
      if (key_right) x_step_s = WALK_S;
      else           x_step_s = -WALK_S;
    end else begin
      x_step_s = 11'sd0;
    end
    x_sum_s = $signed({1'b0, RyuX}) + x_step_s;
    if (x_sum_s < X_MIN_S)      walk_x_s = X_MIN_S[9:0];
    else if (x_sum_s > X_MAX_S) walk_x_s = X_MAX_S[9:0];
    else                        walk_x_s = x_sum_s[9:0];
  end

  // Ballistic step; landing is detected on the step that would reach or pass the ground.
  always_comb begin
    y_next_s = $signed({1'b0, RyuY}) - $signed({{(11-VY_W){vy_r[VY_W-1]}}, vy_r});
    land_s   = (y_next_s >= GROUND_Y_S);
  end

  // Frame-rate FSM with position, velocity and registered sprite/busy outputs.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state_r <= STAND;
      RyuX    <= 10'(X_START);
      RyuY    <= 10'(GROUND_Y);
      sprite  <= SPR_STAND;
      busy    <= 1'b0;
      vy_r    <= {VY_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else if (frame_tick) begin
      case (state_r)
        STAND: begin
          if (jump_edge_s) begin
            state_r <= JUMP;
            vy_r    <= VY_INIT;
            sprite  <= sprite_of(JUMP);
            busy    <= 1'b1;
          end else if (punch_edge_s) begin
            state_r <= PUNCH;
            cnt_r   <= PUNCH_LAST;
            sprite  <= sprite_of(PUNCH);
            busy    <= 1'b1;
          end else begin
            RyuX <= walk_x_s;
          end
        end
        PUNCH: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= STAND;
            sprite  <= sprite_of(STAND);
            busy    <= 1'b0;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        JUMP: begin
`ifdef RYU_AIR_CONTROL_EN
          RyuX <= walk_x_s;
`else
          RyuX <= RyuX;
`endif
          if (land_s) begin
            RyuY    <= GROUND_Y_S[9:0];
            state_r <= STAND;
            sprite  <= sprite_of(STAND);
            busy    <= 1'b0;
          end else begin
            RyuY <= y_next_s[9:0];
            vy_r <= vy_r - GRAV_V;
          end
        end
        default: begin
          state_r <= STAND;
          sprite  <= SPR_STAND;
          busy    <= 1'b0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

endmodule
